// File: rtl/exp6_unidade_controle.sv
// Moore control unit for the memory-sequence game: replays the stored sequence
// on the LEDs each round, then collects and checks the player's moves.
module exp6_unidade_controle #(
    parameter int SHOW_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 12500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic       jogada_feita,
    input  logic       jogada_correta,
    input  logic       enderecoIgualRodada,
    input  logic       fimL,
    input  logic       timeout,
    output logic       zeraCR,
    output logic       contaCR,
    output logic       zeraE,
    output logic       contaE,
    output logic       limpaRC,
    output logic       registraRC,
    output logic       zeraLeds,
    output logic       registraLeds,
    output logic       contaT,
    output logic       led_selector,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        PREPARACAO     = 4'd1,
        CARREGA_LED    = 4'd2,
        EXIBE_LED      = 4'd3,
        APAGA_LED      = 4'd4,
        PROXIMO_LED    = 4'd5,
        INICIO_JOGADAS = 4'd6,
        ESPERA_JOGADA  = 4'd7,
        REGISTRA       = 4'd8,
        COMPARA        = 4'd9,
        PROXIMA_JOGADA = 4'd10,
        PROXIMA_RODADA = 4'd11,
        FIM_ACERTOU    = 4'd12,
        FIM_ERROU      = 4'd13,
        FIM_TIMEOUT    = 4'd14
    } state_t;

    localparam logic [25:0] SHOW_LAST = 26'(SHOW_CYCLES - 1);
    localparam logic [25:0] GAP_LAST  = 26'(GAP_CYCLES - 1);

    state_t      state_r;
    state_t      next_s;
    logic [25:0] count_r;
    logic        show_done_s;
    logic        gap_done_s;

    assign show_done_s = (count_r == SHOW_LAST);
    assign gap_done_s  = (count_r == GAP_LAST);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= INICIAL;
        end else begin
            state_r <= next_s;
        end
    end

    // Display counter: times the lit and dark phases of each sequence entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= 26'd0;
        end else begin
            case (state_r)
                CARREGA_LED: count_r <= 26'd0;
                EXIBE_LED:   count_r <= show_done_s ? 26'd0 : count_r + 26'd1;
                APAGA_LED:   count_r <= count_r + 26'd1;
                default:     count_r <= count_r;
            endcase
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        next_s       = state_r;
        zeraCR       = 1'b0;
        contaCR      = 1'b0;
        zeraE        = 1'b0;
        contaE       = 1'b0;
        limpaRC      = 1'b0;
        registraRC   = 1'b0;
        zeraLeds     = 1'b0;
        registraLeds = 1'b0;
        contaT       = 1'b0;
        led_selector = 1'b0;
        pronto       = 1'b0;
        ganhou       = 1'b0;
        perdeu       = 1'b0;
        db_timeout   = 1'b0;
        case (state_r)
            INICIAL: begin
                if (jogar) next_s = PREPARACAO;
                else       next_s = INICIAL;
            end
            PREPARACAO: begin
                zeraCR   = 1'b1;
                zeraE    = 1'b1;
                limpaRC  = 1'b1;
                zeraLeds = 1'b1;
                next_s   = CARREGA_LED;
            end
            CARREGA_LED: begin
                registraLeds = 1'b1;
                led_selector = 1'b1;
                next_s       = EXIBE_LED;
            end
            EXIBE_LED: begin
                led_selector = 1'b1;
                if (show_done_s) next_s = APAGA_LED;
                else             next_s = EXIBE_LED;
            end
            APAGA_LED: begin
                zeraLeds = 1'b1;
                if (!gap_done_s)              next_s = APAGA_LED;
                else if (enderecoIgualRodada) next_s = INICIO_JOGADAS;
                else                          next_s = PROXIMO_LED;
            end
            PROXIMO_LED: begin
                contaE = 1'b1;
                next_s = CARREGA_LED;
            end
            INICIO_JOGADAS: begin
                zeraE   = 1'b1;
                limpaRC = 1'b1;
                next_s  = ESPERA_JOGADA;
            end
            ESPERA_JOGADA: begin
                contaT = 1'b1;
                // A timeout coinciding with a move still ends the game.
                if (timeout)           next_s = FIM_TIMEOUT;
                else if (jogada_feita) next_s = REGISTRA;
                else                   next_s = ESPERA_JOGADA;
            end
            REGISTRA: begin
                registraRC = 1'b1;
                next_s     = COMPARA;
            end
            COMPARA: begin
                if (!jogada_correta)           next_s = FIM_ERROU;
                else if (!enderecoIgualRodada) next_s = PROXIMA_JOGADA;
                else if (fimL)                 next_s = FIM_ACERTOU;
                else                           next_s = PROXIMA_RODADA;
            end
            PROXIMA_JOGADA: begin
                contaE = 1'b1;
                next_s = ESPERA_JOGADA;
            end
            PROXIMA_RODADA: begin
                contaCR  = 1'b1;
                zeraE    = 1'b1;
                zeraLeds = 1'b1;
                next_s   = CARREGA_LED;
            end
            FIM_ACERTOU: begin
                pronto = 1'b1;
                ganhou = 1'b1;
                if (jogar) next_s = PREPARACAO;
                else       next_s = FIM_ACERTOU;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                perdeu = 1'b1;
                if (jogar) next_s = PREPARACAO;
                else       next_s = FIM_ERROU;
            end
            FIM_TIMEOUT: begin
                pronto     = 1'b1;
                perdeu     = 1'b1;
                db_timeout = 1'b1;
                if (jogar) next_s = PREPARACAO;
                else       next_s = FIM_TIMEOUT;
            end
            default: begin
                next_s = INICIAL;
            end
        endcase
    end

    assign db_estado = state_r;

endmodule

// File: tb/tb_exp6_unidade_controle.sv
// Randomized scoreboard bench for exp6_unidade_controle: a datapath stand-in
// closes the loop while a monitor checks every state run against the expected trace.
module tb_exp6_unidade_controle;

    localparam int SHOW = 4;
    localparam int GAP  = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       jogar = 1'b0;
    logic       jogada_feita = 1'b0;
    logic       jogada_correta = 1'b0;
    logic       timeout = 1'b0;
    logic       enderecoIgualRodada;
    logic       fimL;
    logic       zeraCR, contaCR, zeraE, contaE, limpaRC, registraRC, zeraLeds;
    logic       registraLeds, contaT, led_selector, pronto, ganhou, perdeu, db_timeout;
    logic [3:0] db_estado;
    logic [13:0] outs_s;

    int n_pass = 0;
    int n_chk  = 0;

    typedef struct { int st; int len; } exp_t;
    exp_t sb_q[$];
    logic mon_en = 1'b0;
    int   d_arr [16][16];

    // Datapath stand-in: round counter and address counter.
    logic [3:0] cr = 4'd0;
    logic [3:0] e  = 4'd0;
    assign enderecoIgualRodada = (e == cr);
    assign fimL = (cr == 4'd15);

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (zeraCR) cr <= 4'd0;
        else if (contaCR) cr <= cr + 4'd1;
        if (zeraE) e <= 4'd0;
        else if (contaE) e <= e + 4'd1;
    end

    exp6_unidade_controle #(.SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP)) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .jogada_feita(jogada_feita),
        .jogada_correta(jogada_correta), .enderecoIgualRodada(enderecoIgualRodada),
        .fimL(fimL), .timeout(timeout), .zeraCR(zeraCR), .contaCR(contaCR),
        .zeraE(zeraE), .contaE(contaE), .limpaRC(limpaRC), .registraRC(registraRC),
        .zeraLeds(zeraLeds), .registraLeds(registraLeds), .contaT(contaT),
        .led_selector(led_selector), .pronto(pronto), .ganhou(ganhou),
        .perdeu(perdeu), .db_timeout(db_timeout), .db_estado(db_estado)
    );

    assign outs_s = {zeraCR, contaCR, zeraE, contaE, limpaRC, registraRC, zeraLeds,
                     registraLeds, contaT, led_selector, pronto, ganhou, perdeu, db_timeout};

    // Expected output vector for each state, same bit order as outs_s.
    function automatic logic [13:0] exp_outs(int st);
        case (st)
            1:       return 14'b10101010000000;
            2:       return 14'b00000001010000;
            3:       return 14'b00000000010000;
            4:       return 14'b00000010000000;
            5:       return 14'b00010000000000;
            6:       return 14'b00101000000000;
            7:       return 14'b00000000100000;
            8:       return 14'b00000100000000;
            10:      return 14'b00010000000000;
            11:      return 14'b01100010000000;
            12:      return 14'b00000000001100;
            13:      return 14'b00000000001010;
            14:      return 14'b00000000001011;
            default: return 14'b00000000000000;
        endcase
    endfunction

    task automatic check(string name, int act, int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    endtask

    task automatic push(int st, int len);
        exp_t x;
        x.st = st;
        x.len = len;
        sb_q.push_back(x);
    endtask

    // Expected trace of one game from the timing rules; len 0 means open-ended.
    task automatic build_game(int fr, int fj, int kind);
        push(1, 1);
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i <= r; i++) begin
                push(2, 1); push(3, SHOW); push(4, GAP);
                if (i < r) push(5, 1);
            end
            push(6, 1);
            for (int j = 0; j <= r; j++) begin
                d_arr[r][j] = $urandom_range(0, 3);
                push(7, d_arr[r][j] + 1);
                if (kind >= 2 && r == fr && j == fj) begin
                    push(14, 0);
                    return;
                end
                push(8, 1); push(9, 1);
                if (kind == 1 && r == fr && j == fj) begin
                    push(13, 0);
                    return;
                end
                if (j < r) push(10, 1);
                else if (r == 15) push(12, 0);
                else push(11, 1);
            end
        end
    endtask

    task automatic wait_state(int code, int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clock); #1;
            if (db_estado == 4'(code)) return;
        end
        n_chk++;
        $display("FAIL wait_state%0d actual=%0d expected=%0d (budget expired)", code, db_estado, code);
    endtask

    task automatic drive_game(int fr, int fj, int kind, int hold, bit stray);
        @(posedge clock); #1 jogar = 1'b1;
        repeat (hold) @(posedge clock);
        #1 jogar = 1'b0;
        if (stray) begin
            wait_state(3, 20);
            jogada_feita = 1'b1;
            @(posedge clock); #1 jogada_feita = 1'b0;
        end
        for (int r = 0; r < 16; r++) begin
            for (int j = 0; j <= r; j++) begin
                bit at_fail;
                at_fail = (kind != 0) && (r == fr) && (j == fj);
                wait_state(7, 400);
                repeat (d_arr[r][j]) begin @(posedge clock); #1; end
                jogada_correta = !(at_fail && kind == 1);
                timeout        = at_fail && kind >= 2;
                jogada_feita   = !(at_fail && kind == 3);
                @(posedge clock); #1;
                jogada_feita = 1'b0;
                timeout      = 1'b0;
                if (at_fail) begin
                    wait_state(kind == 1 ? 13 : 14, 20);
                    return;
                end
            end
        end
        wait_state(12, 20);
    endtask

    // Monitor: each new state run pops one expected entry and is checked.
    initial begin
        exp_t cur;
        bit   have_cur;
        int   run_len;
        have_cur = 0;
        run_len  = 0;
        forever begin
            @(negedge clock);
            if (!mon_en) begin
                have_cur = 0;
            end else if (!have_cur || db_estado != 4'(cur.st)) begin
                if (have_cur && cur.len != 0)
                    check($sformatf("run_len_s%0d", cur.st), run_len, cur.len);
                run_len = 1;
                if (sb_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_underflow actual_state=%0d expected=no further state change", db_estado);
                    cur.st = db_estado;
                    cur.len = 0;
                    have_cur = 1;
                end else begin
                    cur = sb_q.pop_front();
                    have_cur = 1;
                    check("state_seq", db_estado, cur.st);
                    check($sformatf("outs_s%0d", cur.st), outs_s, exp_outs(cur.st));
                    cur.st = db_estado;
                end
            end else begin
                run_len++;
            end
        end
    end

    initial begin
        int fr, fj;
        repeat (3) @(posedge clock);
        #1;
        check("reset_state", db_estado, 0);
        check("reset_outs", outs_s, 0);
        push(0, 0);
        reset = 1'b1;
        mon_en = 1'b1;
        repeat (10) @(posedge clock);
        #1 check("idle_state", db_estado, 0);

        build_game(0, 0, 0);
        drive_game(0, 0, 0, 1, 1'b1);
        check("win_ganhou", ganhou, 1);
        check("win_perdeu", perdeu, 0);

        build_game(4, 2, 1);
        drive_game(4, 2, 1, 2, 1'b0);
        check("wrong_perdeu", perdeu, 1);
        check("wrong_ganhou", ganhou, 0);

        fr = $urandom_range(0, 3);
        fj = $urandom_range(0, fr);
        build_game(fr, fj, 2);
        drive_game(fr, fj, 2, 1, 1'b0);
        check("tsim_db_timeout", db_timeout, 1);

        fr = $urandom_range(0, 3);
        fj = $urandom_range(0, fr);
        build_game(fr, fj, 3);
        drive_game(fr, fj, 3, 1, 1'b0);
        check("talone_state", db_estado, 14);

        push(1, 1); push(2, 1); push(3, SHOW);
        @(posedge clock); #1 jogar = 1'b1;
        @(posedge clock); #1 jogar = 1'b0;
        wait_state(3, 20);
        #2 mon_en = 1'b0;
        reset = 1'b0;
        #1;
        check("midreset_state", db_estado, 0);
        check("midreset_outs", outs_s, 0);
        repeat (3) @(posedge clock);
        sb_q.delete();
        push(0, 0);
        #1 reset = 1'b1;
        mon_en = 1'b1;
        repeat (10) @(posedge clock);
        #1 check("idle_after_reset", db_estado, 0);
        check("sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
